// File: rtl/op_dispatch_sequencer.sv
// op_dispatch_sequencer: accepts one decoded op at a time and dispatches it to
//   the linear, circular or dummy motion handler. It then waits for that
//   handler's done and reports completion. It also tracks G90/G91 positioning mode.
// Latency: acceptance -> op_done in 3 cycles minimum (handler rdy already high,
//   done one cycle after trigger); each op holds op_rdy low for at least 3 cycles.
// Backpressure: op_rdy is high only in IDLE. The trigger waits for the selected
//   handler's rdy, and an op stays in flight until that handler's done arrives.
//
// Ports:
//   clk, reset                     system clock, synchronous active-high reset
//   op_cmd/op_valid/op_rdy         op offer handshake (op_cmd latched on accept)
//   sel                            chooser select: 0=dummy 1=linear 2=circular
//   {lin,circ,dummy}_trigger       one-cycle start pulse to the handler
//   {lin,circ,dummy}_rdy           handler idle
//   {lin,circ,dummy}_done          one-cycle completion pulse from the handler
//   abs_mode                       1=absolute (G90), 0=relative (G91)
//   op_done, unknown_cmd           completion pulse, plus an unlisted-command flag
//   timeout                        sticky watchdog flag
//
// Optional build macro OP_TIMEOUT_EN adds the ISSUE/WAIT watchdog (TIMEOUT_CYCLES).
// Without it, timeout is tied low and the dispatcher waits indefinitely.
// Command encodings mirror the Op_PKG OP_CMD_* constants.

module op_dispatch_sequencer #(
  parameter int unsigned CMD_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CMD_W-1:0] op_cmd,
  input  logic             op_valid,
  output logic             op_rdy,
  output logic [1:0]       sel,
  output logic             lin_trigger,
  output logic             circ_trigger,
  output logic             dummy_trigger,
  input  logic             lin_rdy,
  input  logic             circ_rdy,
  input  logic             dummy_rdy,
  input  logic             lin_done,
  input  logic             circ_done,
  input  logic             dummy_done,
  output logic             abs_mode,
  output logic             op_done,
  output logic             unknown_cmd,
  output logic             timeout
);

  localparam logic [3:0] OP_CMD_G00 = 4'h0;
  localparam logic [3:0] OP_CMD_G01 = 4'h1;
  localparam logic [3:0] OP_CMD_G02 = 4'h2;
  localparam logic [3:0] OP_CMD_G03 = 4'h3;
  localparam logic [3:0] OP_CMD_M05 = 4'h4;
  localparam logic [3:0] OP_CMD_G90 = 4'h5;
  localparam logic [3:0] OP_CMD_G91 = 4'h6;

  localparam logic [1:0] SEL_DUMMY = 2'd0;
  localparam logic [1:0] SEL_LIN   = 2'd1;
  localparam logic [1:0] SEL_CIRC  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [1:0]       sel_q, sel_d;
  logic             abs_mode_q, abs_mode_d;

  logic hnd_rdy;
  logic hnd_done;
  logic fire;
  logic expire;
  logic op_timed_out;

  function automatic logic is_cmd(input logic [CMD_W-1:0] c, input logic [3:0] code);
    return c == CMD_W'(code);
  endfunction

  function automatic logic [1:0] sel_of(input logic [CMD_W-1:0] c);
    if (is_cmd(c, OP_CMD_G00) || is_cmd(c, OP_CMD_G01)) return SEL_LIN;
    if (is_cmd(c, OP_CMD_G02) || is_cmd(c, OP_CMD_G03)) return SEL_CIRC;
    return SEL_DUMMY;
  endfunction

  function automatic logic is_listed(input logic [CMD_W-1:0] c);
    return is_cmd(c, OP_CMD_G00) || is_cmd(c, OP_CMD_G01) ||
           is_cmd(c, OP_CMD_G02) || is_cmd(c, OP_CMD_G03) ||
           is_cmd(c, OP_CMD_M05) || is_cmd(c, OP_CMD_G90) ||
           is_cmd(c, OP_CMD_G91);
  endfunction

  // Only the selected handler's rdy/done are observed, so stray done pulses
  // from the other handlers cannot end the current op.
  always_comb begin
    hnd_rdy  = dummy_rdy;
    hnd_done = dummy_done;
    case (sel_q)
      SEL_LIN: begin
        hnd_rdy  = lin_rdy;
        hnd_done = lin_done;
      end
      SEL_CIRC: begin
        hnd_rdy  = circ_rdy;
        hnd_done = circ_done;
      end
      default: begin
        hnd_rdy  = dummy_rdy;
        hnd_done = dummy_done;
      end
    endcase
  end

`ifdef OP_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timed_out_q, timed_out_d;  // current op ended by the watchdog
  logic             timeout_q, timeout_d;      // sticky until reset

  // cnt_q is 0 in the first ISSUE cycle, so a count of TIMEOUT_CYCLES-1 marks
  // the TIMEOUT_CYCLES-th cycle spent in ISSUE/WAIT.
  assign expire       = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) &&
                        (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign op_timed_out = timed_out_q;
  assign timeout      = timeout_q;
`else
  assign expire       = 1'b0;
  assign op_timed_out = 1'b0;
  assign timeout      = 1'b0;
`endif

  // The trigger is a Mealy decode on the handler rdy. This lets it fire in the
  // very first ISSUE cycle in which rdy is seen high.
  assign fire          = (state_q == ST_ISSUE) && hnd_rdy && !expire;
  assign lin_trigger   = fire && (sel_q == SEL_LIN);
  assign circ_trigger  = fire && (sel_q == SEL_CIRC);
  assign dummy_trigger = fire && (sel_q == SEL_DUMMY);

  assign op_rdy      = (state_q == ST_IDLE) && !reset;
  assign op_done     = (state_q == ST_FIN);
  assign unknown_cmd = (state_q == ST_FIN) && !is_listed(cmd_q);
  assign sel         = sel_q;
  assign abs_mode    = abs_mode_q;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    sel_d      = sel_q;
    abs_mode_d = abs_mode_q;
`ifdef OP_TIMEOUT_EN
    cnt_d       = cnt_q;
    timed_out_d = timed_out_q;
    timeout_d   = timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          cmd_d   = op_cmd;
          sel_d   = sel_of(op_cmd);
          state_d = ST_ISSUE;
`ifdef OP_TIMEOUT_EN
          cnt_d       = '0;
          timed_out_d = 1'b0;
`endif
        end
      end
      ST_ISSUE: begin
        if (expire)       state_d = ST_FIN;
        else if (hnd_rdy) state_d = ST_WAIT;
      end
      // A done coincident with the trigger arrives while still in ISSUE and is
      // therefore never seen here.
      ST_WAIT: begin
        if (expire || hnd_done) state_d = ST_FIN;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        // The mode register commits on the FIN edge, so the new mode is visible
        // from the cycle after op_done onwards.
        if (!op_timed_out) begin
          if (is_cmd(cmd_q, OP_CMD_G90))      abs_mode_d = 1'b1;
          else if (is_cmd(cmd_q, OP_CMD_G91)) abs_mode_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef OP_TIMEOUT_EN
    if (expire) begin
      timed_out_d = 1'b1;
      timeout_d   = 1'b1;
    end else if ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      sel_q      <= SEL_DUMMY;
      abs_mode_q <= 1'b1;
`ifdef OP_TIMEOUT_EN
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      sel_q      <= sel_d;
      abs_mode_q <= abs_mode_d;
`ifdef OP_TIMEOUT_EN
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_op_dispatch_sequencer.sv
// tb_op_dispatch_sequencer: directed, table-driven bench for op_dispatch_sequencer.
// Inputs change 1ns after posedge; outputs are sampled on the negedge.
// Cycle index n counts from the acceptance cycle (n=0) of each op.

module tb_op_dispatch_sequencer;

  localparam logic [3:0] G00 = 4'h0;
  localparam logic [3:0] G01 = 4'h1;
  localparam logic [3:0] G02 = 4'h2;
  localparam logic [3:0] G03 = 4'h3;
  localparam logic [3:0] M05 = 4'h4;
  localparam logic [3:0] G90 = 4'h5;
  localparam logic [3:0] G91 = 4'h6;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] op_cmd;
  logic       op_valid;
  logic       op_rdy;
  logic [1:0] sel;
  logic       lin_trigger, circ_trigger, dummy_trigger;
  logic       lin_rdy, circ_rdy, dummy_rdy;
  logic       lin_done, circ_done, dummy_done;
  logic       abs_mode, op_done, unknown_cmd, timeout;

  int checks   = 0;
  int failures = 0;

  op_dispatch_sequencer #(.CMD_W(4), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .op_cmd(op_cmd), .op_valid(op_valid), .op_rdy(op_rdy),
    .sel(sel), .lin_trigger(lin_trigger), .circ_trigger(circ_trigger),
    .dummy_trigger(dummy_trigger), .lin_rdy(lin_rdy), .circ_rdy(circ_rdy),
    .dummy_rdy(dummy_rdy), .lin_done(lin_done), .circ_done(circ_done),
    .dummy_done(dummy_done), .abs_mode(abs_mode), .op_done(op_done),
    .unknown_cmd(unknown_cmd), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cmd;
    int         rdy_dly;   // cycles the selected handler holds rdy low in ISSUE
    bit         spur;      // inject done pulses that must be ignored
    logic [1:0] exp_sel;
    bit         exp_unk;
    bit         exp_abs;   // abs_mode in the cycle after op_done
    int         exp_lat;   // acceptance -> op_done, in cycles
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] trigs();
    return {circ_trigger, lin_trigger, dummy_trigger};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rdy(input logic [2:0] v);
    {circ_rdy, lin_rdy, dummy_rdy} = v;
  endtask

  task automatic set_done(input logic [2:0] v);
    {circ_done, lin_done, dummy_done} = v;
  endtask

  task automatic run_op(input vec_t v, input string tag);
    logic [2:0] exp_oh, trig_seen;
    logic [1:0] sel_seen;
    logic       unk_seen;
    int         n, trig_at, done_at;
    bit         busy_bad, extra_bad;
    exp_oh    = (v.exp_sel == 2'd1) ? 3'b010 : (v.exp_sel == 2'd2) ? 3'b100 : 3'b001;
    trig_seen = 3'b000;
    sel_seen  = 2'd3;
    unk_seen  = 1'b0;
    busy_bad  = 1'b0;
    extra_bad = 1'b0;
    trig_at   = -1;
    done_at   = -1;
    set_rdy((v.rdy_dly > 0) ? ~exp_oh : 3'b111);
    op_cmd   = v.cmd;
    op_valid = 1'b1;
    @(negedge clk);
    check({tag, "_accept_rdy"}, op_rdy, 1);
    tick();
    op_valid = 1'b0;
    op_cmd   = 4'h9;  // changes while busy must have no effect
    n = 1;
    while (n <= 40 && trig_at < 0) begin
      if (n == v.rdy_dly + 1) begin
        set_rdy(3'b111);
        if (v.spur) set_done(exp_oh);  // done together with trigger: ignored
      end
      @(negedge clk);
      if (op_rdy !== 1'b0 || op_done !== 1'b0) busy_bad = 1'b1;
      if (trigs() != 3'b000) begin
        trig_seen = trigs();
        trig_at   = n;
        sel_seen  = sel;
      end
      tick();
      set_done(3'b000);
      n++;
    end
    check({tag, "_trig_cycle"}, trig_at, v.rdy_dly + 1);
    check({tag, "_trig_which"}, trig_seen, exp_oh);
    check({tag, "_sel"}, sel_seen, v.exp_sel);
    check({tag, "_busy_before_trig"}, busy_bad, 0);
    if (v.spur) begin
      for (int s = 0; s < 2; s++) begin
        set_done(~exp_oh);
        @(negedge clk);
        if (op_done !== 1'b0 || trigs() != 3'b000) extra_bad = 1'b1;
        tick();
        set_done(3'b000);
        n++;
      end
    end
    set_done(exp_oh);
    while (n <= 80 && done_at < 0) begin
      @(negedge clk);
      if (trigs() != 3'b000 || op_rdy !== 1'b0) extra_bad = 1'b1;
      if (op_done === 1'b1) begin
        done_at  = n;
        unk_seen = unknown_cmd;
      end
      tick();
      set_done(3'b000);
      n++;
    end
    check({tag, "_op_done_lat"}, done_at, v.exp_lat);
    check({tag, "_unknown_cmd"}, unk_seen, v.exp_unk);
    check({tag, "_no_extra_trig"}, extra_bad, 0);
    @(negedge clk);
    check({tag, "_done_one_pulse"}, op_done, 0);
    check({tag, "_rdy_after"}, op_rdy, 1);
    check({tag, "_abs_mode"}, abs_mode, v.exp_abs);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got 1 expected 0");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vec_t v;
    int   n, done_at;
    bit   trig_bad, to_early;
    //          cmd   dly spur sel unk abs lat
    vecs[0] = '{G01, 0, 0, 2'd1, 0, 1, 3};
    vecs[1] = '{G02, 5, 0, 2'd2, 0, 1, 8};
    vecs[2] = '{G91, 0, 0, 2'd0, 0, 0, 3};
    vecs[3] = '{G00, 0, 0, 2'd1, 0, 0, 3};
    vecs[4] = '{G90, 0, 0, 2'd0, 0, 1, 3};
    vecs[5] = '{G03, 0, 1, 2'd2, 0, 1, 5};
    vecs[6] = '{M05, 0, 0, 2'd0, 0, 1, 3};
    vecs[7] = '{4'hF, 0, 0, 2'd0, 1, 1, 3};
    vecs[8] = '{4'h7, 2, 0, 2'd0, 1, 1, 5};
    vecs[9] = '{G91, 0, 0, 2'd0, 0, 0, 3};

    reset    = 1'b1;
    op_cmd   = 4'h0;
    op_valid = 1'b1;
    set_rdy(3'b111);
    set_done(3'b000);
    tick();
    tick();
    @(negedge clk);
    check("rst_rdy_low", op_rdy, 0);
    check("rst_triggers", trigs(), 0);
    tick();
    reset    = 1'b0;
    op_valid = 1'b0;
    @(negedge clk);
    check("rst_rdy_first_cycle", op_rdy, 1);
    check("rst_sel", sel, 0);
    check("rst_abs_mode", abs_mode, 1);
    check("rst_op_done", op_done, 0);
    check("rst_unknown", unknown_cmd, 0);
    check("rst_timeout", timeout, 0);
    tick();

    for (int i = 0; i < 10; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Reset in WAIT of a G01: abs_mode was left at 0 by the last vector.
    set_rdy(3'b111);
    op_cmd   = G01;
    op_valid = 1'b1;
    @(negedge clk);
    check("mid_rst_accept", op_rdy, 1);
    tick();
    op_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_trig", trigs(), 3'b010);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_rdy_low", op_rdy, 0);
    tick();
    reset    = 1'b0;
    lin_done = 1'b1;
    @(negedge clk);
    check("mid_rst_rdy", op_rdy, 1);
    check("mid_rst_sel", sel, 0);
    check("mid_rst_abs", abs_mode, 1);
    check("mid_rst_op_done", op_done, 0);
    check("mid_rst_trigs", trigs(), 0);
    tick();
    lin_done = 1'b0;
    @(negedge clk);
    check("late_done_ignored", op_done, 0);
    check("late_done_rdy", op_rdy, 1);
    tick();

`ifdef OP_TIMEOUT_EN
    // Dummy handler never completes a G91: watchdog ends it, abs_mode untouched.
    set_rdy(3'b111);
    op_cmd   = G91;
    op_valid = 1'b1;
    @(negedge clk);
    check("to_accept", op_rdy, 1);
    tick();
    op_valid = 1'b0;
    n        = 1;
    done_at  = -1;
    trig_bad = 1'b0;
    to_early = 1'b0;
    @(negedge clk);
    check("to_trig", trigs(), 3'b001);
    tick();
    n = 2;
    while (n <= 60 && done_at < 0) begin
      @(negedge clk);
      if (trigs() != 3'b000) trig_bad = 1'b1;
      if (op_done === 1'b1) begin
        done_at = n;
        check("to_flag_with_done", timeout, 1);
      end else if (timeout !== 1'b0) begin
        to_early = 1'b1;
      end
      tick();
      n++;
    end
    check("to_op_done_lat", done_at, 21);
    check("to_no_early_flag", to_early, 0);
    check("to_no_retrigger", trig_bad, 0);
    @(negedge clk);
    check("to_abs_unchanged", abs_mode, 1);
    check("to_sticky", timeout, 1);
    tick();
    v = '{G01, 0, 0, 2'd1, 0, 1, 3};
    run_op(v, "after_to");
    @(negedge clk);
    check("to_still_set", timeout, 1);
    tick();
`else
    @(negedge clk);
    check("timeout_tied_low", timeout, 0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
